sc_frog_position_register: RTL and testbench
============================================

Name: sc_frog_position_register

Overview:
- Responder to the point state machine's control bus.
- Consumes its active-low clear/load0/load1 strobes and its 2-bit shift selection, and holds the frog position on a ROWS x COLS playfield.
- Drives the one-hot position matrix to the display path.
- Returns the active-low "frog in first (bottom) register" flag, which the state machine uses to gate DOWN moves.

Parameters:
- ROWS, 8, number of playfield rows; row 0 is the bottom/start row, ROWS-1 is the goal row.
- COLS, 8, number of columns; column 0 is leftmost.
- START_COL, 3, column loaded on reset or clear; must be less than COLS.
- CNT_W, 8, width of the accepted-move counter.

Ports:
- SC_FROGPOS_CLOCK_50  in  1  system clock, 50 MHz.
- SC_FROGPOS_RESET_InLow  in  1  asynchronous, active-low reset.
- SC_FROGPOS_clear_InLow  in  1  re-initialise position, goal flag and counter.
- SC_FROGPOS_load0_InLow  in  1  move up one row.
- SC_FROGPOS_load1_InLow  in  1  move down one row.
- SC_FROGPOS_shiftselection_In  in  2  01 = left, 10 = right, 11 or 00 = hold.
- SC_FROGPOS_matrix_Out  out  ROWS*COLS  one-hot position; row r occupies bits [r*COLS +: COLS], column c is bit c within the row.
- SC_FROGPOS_FirstRegister_OutLow  out  1  0 when the frog is in row 0, else 1.
- SC_FROGPOS_goal_OutHigh  out  1  sticky; set when an UP is requested while in row ROWS-1.
- SC_FROGPOS_moved_OutHigh  out  1  one-cycle pulse on every accepted move.
- SC_FROGPOS_moves_Out  out  CNT_W  count of accepted moves, saturating.

Behaviour:
- State registers: row index, col index, goal, moved, moves. All are reset asynchronously when RESET_InLow=0.
- Reset values:
  - row=0, col=START_COL, so the matrix has only bit START_COL set.
  - FirstRegister_OutLow=0, goal=0, moved=0, moves=0.
- Control inputs are sampled on the rising clock edge; the new position is visible in the cycle after the strobe.
- matrix_Out and FirstRegister_OutLow are combinational decodes of the registered row/col; they add no latency.
- Exactly one command is executed per edge, in this priority order: clear > load0 > load1 > shift > hold.
- clear: row=0, col=START_COL, goal=0, moves=0, moved=0.
- load0 (up):
  - row < ROWS-1: row+1, the move is accepted.
  - row = ROWS-1: position holds, goal<=1, the move is not counted.
- load1 (down):
  - row > 0: row-1, the move is accepted.
  - row = 0: no-op. This is required even though the state machine normally blocks it.
- shift 01 (left): col>0 gives col-1 and is accepted; col=0 holds with no wrap.
- shift 10 (right): col<COLS-1 gives col+1 and is accepted; col=COLS-1 holds with no wrap.
- Shift codes 11 and 00 hold.
- Accepted move: moved<=1 for one cycle, moves<=moves+1, saturating at 2^CNT_W-1. Any rejected or no-op command gives moved<=0.
- Once set, goal stays 1 until clear or reset. Moves are still accepted while goal=1.
- Strobe handling is level-based: a strobe held low for N cycles executes N times. The state machine guarantees single-cycle strobes through its CHECK_1 release wait.
- Reset asserted mid-operation forces all reset values immediately, regardless of the clock. Deassertion takes effect at the next edge.
- Index widths are $clog2(ROWS) and $clog2(COLS). The decoder must not set any matrix bit for out-of-range indices; unreachable by construction, but required.

Decomposition:
- Shared package sc_frog_pkg holds:
  - shift code constants SHIFT_LEFT=2'b01, SHIFT_RIGHT=2'b10, SHIFT_HOLD=2'b11;
  - default ROWS/COLS/START_COL;
  - a command enum {CMD_HOLD, CMD_CLEAR, CMD_UP, CMD_DOWN, CMD_LEFT, CMD_RIGHT} for the priority encoder.
- One sub-module: sc_frog_position_decoder, a combinational row/col index to one-hot ROWS*COLS matrix decoder. It is reused by the display and collision blocks.

Test Plan:
- Reset low, then high, with defaults → matrix bit 3 only = 0x...0008, FirstRegister_OutLow=0, goal=0, moves=0.
- Four single-cycle load0 strobes → row=4, matrix bit 35 set, FirstRegister_OutLow=1, moves=4, moved pulses once per strobe.
- From reset, load1 strobe → position unchanged, moved=0, moves=0. Then 4 left strobes → col=0 after 3; 4th holds with moves=3.
- 7 ups to row 7, then 1 more up → goal=1, row stays 7, moves=7. Then clear → bit 3 only, goal=0, moves=0.
- load0, load1 and shift=01 low in the same cycle → only the up executes (row+1, col unchanged). clear plus load0 together → clear wins.
- Reset pulsed low between clock edges while at row 5, col 6 → outputs return to reset values within that cycle without waiting for a clock edge.

Source files
------------

// File: rtl/sc_frog_pkg.sv
// rtl/sc_frog_pkg.sv - shared constants and command encoding for the frog position logic
//
// Purpose: shift selection codes, default playfield geometry and the command
// enum used by the position register's priority encoder.
// Ports: none (package).

package sc_frog_pkg;

  localparam logic [1:0] SHIFT_LEFT  = 2'b01;
  localparam logic [1:0] SHIFT_RIGHT = 2'b10;
  localparam logic [1:0] SHIFT_HOLD  = 2'b11;

  localparam int DEFAULT_ROWS      = 8;
  localparam int DEFAULT_COLS      = 8;
  localparam int DEFAULT_START_COL = 3;

  typedef enum logic [2:0] {
    CMD_HOLD  = 3'd0,
    CMD_CLEAR = 3'd1,
    CMD_UP    = 3'd2,
    CMD_DOWN  = 3'd3,
    CMD_LEFT  = 3'd4,
    CMD_RIGHT = 3'd5
  } cmd_e;

endpackage

// File: rtl/sc_frog_position_decoder.sv
// rtl/sc_frog_position_decoder.sv - row/col index to one-hot playfield matrix
//
// Purpose: combinational decode of a (row, col) index pair into a one-hot
// ROWS*COLS matrix; row r occupies bits [r*COLS +: COLS], column c is bit c
// within the row. Indices outside the playfield set no bit.
// Ports:
//   row_i    in  RW         row index
//   col_i    in  CW         column index
//   matrix_o out ROWS*COLS  one-hot position (all zero if out of range)

module sc_frog_position_decoder
  import sc_frog_pkg::*;
#(
  parameter int ROWS = DEFAULT_ROWS,
  parameter int COLS = DEFAULT_COLS,
  parameter int RW   = (ROWS > 1) ? $clog2(ROWS) : 1,
  parameter int CW   = (COLS > 1) ? $clog2(COLS) : 1
) (
  input  logic [RW-1:0]        row_i,
  input  logic [CW-1:0]        col_i,
  output logic [ROWS*COLS-1:0] matrix_o
);

  // Each bit compares against its own constant coordinates, so an index that
  // names no real row/column simply matches nothing.
  always_comb begin
    matrix_o = '0;
    for (int r = 0; r < ROWS; r++) begin
      for (int c = 0; c < COLS; c++) begin
        matrix_o[r*COLS + c] = (row_i == RW'(r)) && (col_i == CW'(c));
      end
    end
  end

endmodule

// File: rtl/sc_frog_position_register.sv
// rtl/sc_frog_position_register.sv - frog position register on the point FSM control bus
//
// Purpose: holds the frog row/column, executes one command per clock in
// priority clear > up > down > shift > hold, tracks the sticky goal flag and a
// saturating count of accepted moves, and drives the one-hot position matrix.
// Ports:
//   SC_FROGPOS_CLOCK_50              in   1          system clock
//   SC_FROGPOS_RESET_InLow           in   1          async active-low reset
//   SC_FROGPOS_clear_InLow           in   1          re-initialise position/goal/counter
//   SC_FROGPOS_load0_InLow           in   1          move up one row
//   SC_FROGPOS_load1_InLow           in   1          move down one row
//   SC_FROGPOS_shiftselection_In     in   2          01 left, 10 right, else hold
//   SC_FROGPOS_matrix_Out            out  ROWS*COLS  one-hot position
//   SC_FROGPOS_FirstRegister_OutLow  out  1          0 while in row 0
//   SC_FROGPOS_goal_OutHigh          out  1          sticky goal-reached flag
//   SC_FROGPOS_moved_OutHigh         out  1          pulse per accepted move
//   SC_FROGPOS_moves_Out             out  CNT_W      saturating accepted-move count

module sc_frog_position_register
  import sc_frog_pkg::*;
#(
  parameter int ROWS      = DEFAULT_ROWS,
  parameter int COLS      = DEFAULT_COLS,
  parameter int START_COL = DEFAULT_START_COL,
  parameter int CNT_W     = 8
) (
  input  logic                 SC_FROGPOS_CLOCK_50,
  input  logic                 SC_FROGPOS_RESET_InLow,
  input  logic                 SC_FROGPOS_clear_InLow,
  input  logic                 SC_FROGPOS_load0_InLow,
  input  logic                 SC_FROGPOS_load1_InLow,
  input  logic [1:0]           SC_FROGPOS_shiftselection_In,
  output logic [ROWS*COLS-1:0] SC_FROGPOS_matrix_Out,
  output logic                 SC_FROGPOS_FirstRegister_OutLow,
  output logic                 SC_FROGPOS_goal_OutHigh,
  output logic                 SC_FROGPOS_moved_OutHigh,
  output logic [CNT_W-1:0]     SC_FROGPOS_moves_Out
);

  localparam int RW = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam int CW = (COLS > 1) ? $clog2(COLS) : 1;

  localparam logic [RW-1:0] ROW_TOP   = RW'(ROWS - 1);
  localparam logic [CW-1:0] COL_RIGHT = CW'(COLS - 1);
  localparam logic [CW-1:0] COL_START = CW'(START_COL);

  logic           clk;
  logic           rst_n;
  cmd_e           cmd;

  logic [RW-1:0]    row_q, row_d;
  logic [CW-1:0]    col_q, col_d;
  logic             goal_q, goal_d;
  logic             moved_q, moved_d;
  logic [CNT_W-1:0] moves_q, moves_d;
  logic             accept;

  assign clk   = SC_FROGPOS_CLOCK_50;
  assign rst_n = SC_FROGPOS_RESET_InLow;

  // Priority encoder: exactly one command per edge.
  always_comb begin
    cmd = CMD_HOLD;
    if (!SC_FROGPOS_clear_InLow) begin
      cmd = CMD_CLEAR;
    end else if (!SC_FROGPOS_load0_InLow) begin
      cmd = CMD_UP;
    end else if (!SC_FROGPOS_load1_InLow) begin
      cmd = CMD_DOWN;
    end else if (SC_FROGPOS_shiftselection_In == SHIFT_LEFT) begin
      cmd = CMD_LEFT;
    end else if (SC_FROGPOS_shiftselection_In == SHIFT_RIGHT) begin
      cmd = CMD_RIGHT;
    end
  end

  always_comb begin
    row_d   = row_q;
    col_d   = col_q;
    goal_d  = goal_q;
    accept  = 1'b0;
    case (cmd)
      CMD_CLEAR: begin
        row_d  = '0;
        col_d  = COL_START;
        goal_d = 1'b0;
      end
      CMD_UP: begin
        // An UP from the goal row is how the goal is reached; it does not move.
        if (row_q == ROW_TOP) begin
          goal_d = 1'b1;
        end else begin
          row_d  = row_q + 1'b1;
          accept = 1'b1;
        end
      end
      CMD_DOWN: begin
        if (row_q != '0) begin
          row_d  = row_q - 1'b1;
          accept = 1'b1;
        end
      end
      CMD_LEFT: begin
        if (col_q != '0) begin
          col_d  = col_q - 1'b1;
          accept = 1'b1;
        end
      end
      CMD_RIGHT: begin
        if (col_q != COL_RIGHT) begin
          col_d  = col_q + 1'b1;
          accept = 1'b1;
        end
      end
      default: ;
    endcase

    moved_d = accept;
    moves_d = moves_q;
    if (cmd == CMD_CLEAR) begin
      moves_d = '0;
    end else if (accept && (moves_q != '1)) begin
      moves_d = moves_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      row_q   <= '0;
      col_q   <= COL_START;
      goal_q  <= 1'b0;
      moved_q <= 1'b0;
      moves_q <= '0;
    end else begin
      row_q   <= row_d;
      col_q   <= col_d;
      goal_q  <= goal_d;
      moved_q <= moved_d;
      moves_q <= moves_d;
    end
  end

  sc_frog_position_decoder #(
    .ROWS (ROWS),
    .COLS (COLS),
    .RW   (RW),
    .CW   (CW)
  ) u_decoder (
    .row_i    (row_q),
    .col_i    (col_q),
    .matrix_o (SC_FROGPOS_matrix_Out)
  );

  assign SC_FROGPOS_FirstRegister_OutLow = (row_q != '0);
  assign SC_FROGPOS_goal_OutHigh         = goal_q;
  assign SC_FROGPOS_moved_OutHigh        = moved_q;
  assign SC_FROGPOS_moves_Out            = moves_q;

endmodule

// File: tb/tb_sc_frog_position_register.sv
// tb/tb_sc_frog_position_register.sv - directed self-checking bench for sc_frog_position_register

module tb_sc_frog_position_register;

  logic        clk;
  logic        rst_n;
  logic        clr_n;
  logic        l0_n;
  logic        l1_n;
  logic [1:0]  sh;
  logic [63:0] matrix;
  logic        first_n;
  logic        goal;
  logic        moved;
  logic [7:0]  moves;

  int n_cmp;
  int n_fail;

  sc_frog_position_register #(
    .ROWS(8), .COLS(8), .START_COL(3), .CNT_W(8)
  ) dut (
    .SC_FROGPOS_CLOCK_50             (clk),
    .SC_FROGPOS_RESET_InLow          (rst_n),
    .SC_FROGPOS_clear_InLow          (clr_n),
    .SC_FROGPOS_load0_InLow          (l0_n),
    .SC_FROGPOS_load1_InLow          (l1_n),
    .SC_FROGPOS_shiftselection_In    (sh),
    .SC_FROGPOS_matrix_Out           (matrix),
    .SC_FROGPOS_FirstRegister_OutLow (first_n),
    .SC_FROGPOS_goal_OutHigh         (goal),
    .SC_FROGPOS_moved_OutHigh        (moved),
    .SC_FROGPOS_moves_Out            (moves)
  );

  initial clk = 1'b0;
  always #10 clk = ~clk;

  function automatic logic [63:0] pos(input int r, input int c);
    logic [63:0] one;
    one = 64'd1;
    return one << (r*8 + c);
  endfunction

  // Drive one command for exactly one rising edge, then go idle.
  task automatic cyc(input logic c_n, input logic u_n, input logic d_n, input logic [1:0] s);
    @(negedge clk);
    clr_n = c_n; l0_n = u_n; l1_n = d_n; sh = s;
    @(posedge clk);
    #1;
    clr_n = 1'b1; l0_n = 1'b1; l1_n = 1'b1; sh = 2'b00;
  endtask

  task automatic up();    cyc(1'b1, 1'b0, 1'b1, 2'b00); endtask
  task automatic down();  cyc(1'b1, 1'b1, 1'b0, 2'b00); endtask
  task automatic left();  cyc(1'b1, 1'b1, 1'b1, 2'b01); endtask
  task automatic right(); cyc(1'b1, 1'b1, 1'b1, 2'b10); endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    n_cmp++; if (matrix !== 64'h8) begin n_fail++; $display("FAIL reset_matrix got %h exp %h", matrix, 64'h8); end
    n_cmp++; if (first_n !== 1'b0) begin n_fail++; $display("FAIL reset_first got %b exp 0", first_n); end
    n_cmp++; if (goal !== 1'b0) begin n_fail++; $display("FAIL reset_goal got %b exp 0", goal); end
    n_cmp++; if (moves !== 8'd0) begin n_fail++; $display("FAIL reset_moves got %0d exp 0", moves); end
    n_cmp++; if (moved !== 1'b0) begin n_fail++; $display("FAIL reset_moved got %b exp 0", moved); end
  endtask

  task automatic test_up();
    do_reset();
    for (int i = 1; i <= 4; i++) begin
      up();
      n_cmp++; if (moved !== 1'b1) begin n_fail++; $display("FAIL up_moved[%0d] got %b exp 1", i, moved); end
      n_cmp++; if (moves !== 8'(i)) begin n_fail++; $display("FAIL up_moves[%0d] got %0d exp %0d", i, moves, i); end
    end
    n_cmp++; if (matrix !== pos(4, 3)) begin n_fail++; $display("FAIL up_matrix got %h exp %h", matrix, pos(4, 3)); end
    n_cmp++; if (first_n !== 1'b1) begin n_fail++; $display("FAIL up_first got %b exp 1", first_n); end
    @(posedge clk); #1;
    n_cmp++; if (moved !== 1'b0) begin n_fail++; $display("FAIL up_pulse_end got %b exp 0", moved); end
  endtask

  task automatic test_down_left();
    do_reset();
    down();
    n_cmp++; if (matrix !== 64'h8) begin n_fail++; $display("FAIL down0_matrix got %h exp %h", matrix, 64'h8); end
    n_cmp++; if (moved !== 1'b0) begin n_fail++; $display("FAIL down0_moved got %b exp 0", moved); end
    n_cmp++; if (moves !== 8'd0) begin n_fail++; $display("FAIL down0_moves got %0d exp 0", moves); end
    for (int i = 1; i <= 3; i++) begin
      left();
      n_cmp++; if (matrix !== pos(0, 3 - i)) begin n_fail++; $display("FAIL left_matrix[%0d] got %h exp %h", i, matrix, pos(0, 3 - i)); end
      n_cmp++; if (moved !== 1'b1) begin n_fail++; $display("FAIL left_moved[%0d] got %b exp 1", i, moved); end
    end
    left();
    n_cmp++; if (matrix !== pos(0, 0)) begin n_fail++; $display("FAIL left_edge_matrix got %h exp %h", matrix, pos(0, 0)); end
    n_cmp++; if (moved !== 1'b0) begin n_fail++; $display("FAIL left_edge_moved got %b exp 0", moved); end
    n_cmp++; if (moves !== 8'd3) begin n_fail++; $display("FAIL left_edge_moves got %0d exp 3", moves); end
  endtask

  task automatic test_goal_clear();
    do_reset();
    for (int i = 0; i < 7; i++) up();
    n_cmp++; if (matrix !== pos(7, 3)) begin n_fail++; $display("FAIL top_matrix got %h exp %h", matrix, pos(7, 3)); end
    n_cmp++; if (goal !== 1'b0) begin n_fail++; $display("FAIL top_goal_early got %b exp 0", goal); end
    up();
    n_cmp++; if (goal !== 1'b1) begin n_fail++; $display("FAIL goal_set got %b exp 1", goal); end
    n_cmp++; if (matrix !== pos(7, 3)) begin n_fail++; $display("FAIL goal_matrix got %h exp %h", matrix, pos(7, 3)); end
    n_cmp++; if (moves !== 8'd7) begin n_fail++; $display("FAIL goal_moves got %0d exp 7", moves); end
    n_cmp++; if (moved !== 1'b0) begin n_fail++; $display("FAIL goal_moved got %b exp 0", moved); end
    // Moves still count while goal is set; right edge must not wrap.
    for (int i = 0; i < 5; i++) right();
    n_cmp++; if (matrix !== pos(7, 7)) begin n_fail++; $display("FAIL right_edge_matrix got %h exp %h", matrix, pos(7, 7)); end
    n_cmp++; if (moves !== 8'd11) begin n_fail++; $display("FAIL right_edge_moves got %0d exp 11", moves); end
    n_cmp++; if (goal !== 1'b1) begin n_fail++; $display("FAIL goal_sticky got %b exp 1", goal); end
    cyc(1'b0, 1'b1, 1'b1, 2'b00);
    n_cmp++; if (matrix !== 64'h8) begin n_fail++; $display("FAIL clear_matrix got %h exp %h", matrix, 64'h8); end
    n_cmp++; if (goal !== 1'b0) begin n_fail++; $display("FAIL clear_goal got %b exp 0", goal); end
    n_cmp++; if (moves !== 8'd0) begin n_fail++; $display("FAIL clear_moves got %0d exp 0", moves); end
  endtask

  task automatic test_priority();
    do_reset();
    cyc(1'b1, 1'b0, 1'b0, 2'b01);
    n_cmp++; if (matrix !== pos(1, 3)) begin n_fail++; $display("FAIL prio_up_matrix got %h exp %h", matrix, pos(1, 3)); end
    n_cmp++; if (moves !== 8'd1) begin n_fail++; $display("FAIL prio_up_moves got %0d exp 1", moves); end
    cyc(1'b1, 1'b1, 1'b0, 2'b10);
    n_cmp++; if (matrix !== pos(0, 3)) begin n_fail++; $display("FAIL prio_down_matrix got %h exp %h", matrix, pos(0, 3)); end
    up();
    cyc(1'b0, 1'b0, 1'b1, 2'b00);
    n_cmp++; if (matrix !== 64'h8) begin n_fail++; $display("FAIL prio_clear_matrix got %h exp %h", matrix, 64'h8); end
    n_cmp++; if (moves !== 8'd0) begin n_fail++; $display("FAIL prio_clear_moves got %0d exp 0", moves); end
    cyc(1'b1, 1'b1, 1'b1, 2'b11);
    n_cmp++; if (matrix !== 64'h8 || moved !== 1'b0) begin n_fail++; $display("FAIL hold11 got %h/%b exp %h/0", matrix, moved, 64'h8); end
  endtask

  task automatic test_saturate();
    do_reset();
    for (int i = 0; i < 130; i++) begin
      up();
      down();
    end
    n_cmp++; if (moves !== 8'd255) begin n_fail++; $display("FAIL sat_moves got %0d exp 255", moves); end
    n_cmp++; if (moved !== 1'b1) begin n_fail++; $display("FAIL sat_moved got %b exp 1", moved); end
  endtask

  task automatic test_async_reset();
    do_reset();
    for (int i = 0; i < 5; i++) up();
    for (int i = 0; i < 3; i++) right();
    n_cmp++; if (matrix !== pos(5, 6)) begin n_fail++; $display("FAIL pre_rst_matrix got %h exp %h", matrix, pos(5, 6)); end
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    n_cmp++; if (matrix !== 64'h8) begin n_fail++; $display("FAIL async_matrix got %h exp %h", matrix, 64'h8); end
    n_cmp++; if (first_n !== 1'b0) begin n_fail++; $display("FAIL async_first got %b exp 0", first_n); end
    n_cmp++; if (moves !== 8'd0) begin n_fail++; $display("FAIL async_moves got %0d exp 0", moves); end
    #2;
    rst_n = 1'b1;
    @(posedge clk); #1;
    n_cmp++; if (matrix !== 64'h8 || moved !== 1'b0) begin n_fail++; $display("FAIL post_rst got %h/%b exp %h/0", matrix, moved, 64'h8); end
  endtask

  initial begin
    n_cmp = 0; n_fail = 0;
    rst_n = 1'b0; clr_n = 1'b1; l0_n = 1'b1; l1_n = 1'b1; sh = 2'b00;
    test_reset();
    test_up();
    test_down_left();
    test_goal_clear();
    test_priority();
    test_saturate();
    test_async_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
